mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 131 +++++++++++++
 tb/tb_mdu_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Handshake and result bus between the pipeline and the multiply/divide unit.
interface mdu_ctrl_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDUse_D;
    logic        Busy;
    logic        Stall_MD;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, MDOp, A, B, MDUse_D,
        input  Busy, Stall_MD, Done, HI, LO
    );

    modport slave (
        input  Start, MDOp, A, B, MDUse_D,
        output Busy, Stall_MD, Done, HI, LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: latches operands at Start, holds Busy
// for a fixed latency, then commits HI/LO and pulses Done.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        Reset,
    mdu_ctrl_if.slave   mdu
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    // One multiplier and one unsigned divider serve both signed and unsigned forms.
    logic [63:0] mul_a, mul_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b, uq, ur, quot, rem;

    always_comb begin
        mul_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        mul_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod  = mul_a * mul_b;

        a_neg = sgn_q & a_q[31];
        b_neg = sgn_q & b_q[31];
        abs_a = a_neg ? (~a_q + 32'd1) : a_q;
        abs_b = b_neg ? (~b_q + 32'd1) : b_q;
        uq    = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
        ur    = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
        quot  = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem   = a_neg ? (~ur + 32'd1) : ur;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mdu.Start) begin
                    case (mdu.MDOp)
                        3'b000, 3'b001: begin
                            a_d     = mdu.A;
                            b_d     = mdu.B;
                            sgn_d   = ~mdu.MDOp[0];
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = S_MULT;
                        end
                        3'b010, 3'b011: begin
                            a_d     = mdu.A;
                            b_d     = mdu.B;
                            sgn_d   = ~mdu.MDOp[0];
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            state_d = S_DIV;
                        end
                        3'b100:  hi_d = mdu.A;
                        3'b101:  lo_d = mdu.A;
                        default: ;
                    endcase
                end
            end
            S_MULT: begin
                if (cnt_q == '0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    // A zero divisor still runs the full latency but leaves HI/LO alone.
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign mdu.Busy     = (state_q != S_IDLE);
    assign mdu.Done     = done_q;
    assign mdu.HI       = hi_q;
    assign mdu.LO       = lo_q;
    assign mdu.Stall_MD = mdu.MDUse_D & (mdu.Busy | (mdu.Start & ~mdu.MDOp[2]));
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, results, ignored starts, divide by zero, reset abort.
module tb_mdu_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .CLK   (clk),
        .Reset (rst_n),
        .mdu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc, input logic [31:0] eh,
                          input logic [31:0] el, input bit disturb);
        bus.Start = 1'b1;
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        #1;
        chk({tag, "_stall_start"}, {31'b0, bus.Stall_MD}, {31'b0, bus.MDUse_D});
        step();
        bus.Start = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            chk({tag, "_busy"}, {31'b0, bus.Busy}, 32'd1);
            chk({tag, "_nodone"}, {31'b0, bus.Done}, 32'd0);
            chk({tag, "_stall_busy"}, {31'b0, bus.Stall_MD}, {31'b0, bus.MDUse_D});
            $display("%s busy cycle %0d HI=%h LO=%h", tag, i, bus.HI, bus.LO);
            if (disturb) begin
                if (i == 1) begin
                    bus.Start = 1'b1; bus.MDOp = 3'b010; bus.A = 32'd9; bus.B = 32'd3;
                end else if (i == 2) begin
                    bus.Start = 1'b0; bus.A = 32'h5555_5555; bus.B = 32'h0000_0007;
                end else if (i == ncyc - 1) begin
                    bus.Start = 1'b1; bus.MDOp = 3'b100; bus.A = 32'h0000_DEAD;
                end
            end
            step();
        end
        bus.Start = 1'b0;
        chk({tag, "_idle"}, {31'b0, bus.Busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, bus.Done}, 32'd1);
        chk({tag, "_hi"}, bus.HI, eh);
        chk({tag, "_lo"}, bus.LO, el);
        $display("%s done HI=%h LO=%h", tag, bus.HI, bus.LO);
        step();
        chk({tag, "_done_clr"}, {31'b0, bus.Done}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.MDOp  = 3'b000;
        bus.A     = '0;
        bus.B     = '0;
        bus.MDUse_D = 1'b0;
        step();
        step();
        chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("rst_done", {31'b0, bus.Done}, 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        bus.MDUse_D = 1'b1;
        bus.Start   = 1'b1;
        #1;
        chk("rst_stall_comb", {31'b0, bus.Stall_MD}, 32'd1);
        bus.Start = 1'b0;
        rst_n = 1'b1;
        step();

        // signed mult with stall held
        run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        chk("mult_stall_after", {31'b0, bus.Stall_MD}, 32'd0);

        // multu with operand changes, a mid-busy Start and a Start on the last busy cycle
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);

        bus.MDUse_D = 1'b0;
        run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);
        run_op("divu", 3'b011, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
        run_op("div_neg_div", 3'b010, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 1'b0);

        // back-to-back mthi / mtlo
        bus.Start = 1'b1; bus.MDOp = 3'b100; bus.A = 32'h0000_1234;
        step();
        chk("mthi_busy", {31'b0, bus.Busy}, 32'd0);
        chk("mthi_hi", bus.HI, 32'h0000_1234);
        bus.MDOp = 3'b101; bus.A = 32'h0000_5678;
        step();
        bus.Start = 1'b0;
        chk("mtlo_busy", {31'b0, bus.Busy}, 32'd0);
        chk("mtlo_done", {31'b0, bus.Done}, 32'd0);
        chk("mtlo_hi", bus.HI, 32'h0000_1234);
        chk("mtlo_lo", bus.LO, 32'h0000_5678);
        $display("mthi/mtlo HI=%h LO=%h", bus.HI, bus.LO);
        step();
        chk("mt_nodone", {31'b0, bus.Done}, 32'd0);

        // no-op codes leave everything alone
        bus.Start = 1'b1; bus.MDOp = 3'b110; bus.A = 32'hFFFF_0000; bus.B = 32'd1;
        step();
        bus.MDOp = 3'b111;
        step();
        bus.Start = 1'b0;
        chk("noop_busy", {31'b0, bus.Busy}, 32'd0);
        chk("noop_hi", bus.HI, 32'h0000_1234);
        chk("noop_lo", bus.LO, 32'h0000_5678);
        $display("noop HI=%h LO=%h", bus.HI, bus.LO);

        // divu by zero keeps prior HI/LO
        bus.Start = 1'b1; bus.MDOp = 3'b100; bus.A = 32'h11;
        step();
        bus.MDOp = 3'b101; bus.A = 32'h22;
        step();
        run_op("divu_zero", 3'b011, 32'd7, 32'd0, 10, 32'h11, 32'h22, 1'b0);

        // reset in the third busy cycle aborts the operation
        bus.Start = 1'b1; bus.MDOp = 3'b000; bus.A = 32'd3; bus.B = 32'd4;
        step();
        bus.Start = 1'b0;
        step();
        step();
        chk("abort_busy_pre", {31'b0, bus.Busy}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("abort_busy", {31'b0, bus.Busy}, 32'd0);
        chk("abort_hi", bus.HI, 32'd0);
        chk("abort_lo", bus.LO, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_nodone", {31'b0, bus.Done}, 32'd0);
            chk("abort_idle", {31'b0, bus.Busy}, 32'd0);
        end
        chk("abort_hi_after", bus.HI, 32'd0);
        chk("abort_lo_after", bus.LO, 32'd0);
        $display("abort HI=%h LO=%h", bus.HI, bus.LO);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
